vga_scanout: RTL

Scanout stage downstream of the processor's image framebuffer: generates 640x480@60 Hz VGA timing from the 50 MHz system clock and reads 8-bit grayscale pixels from a synchronous-read framebuffer port. It drives the video DAC through the r/g/b, sync and blank outputs, plus the derived 25 MHz pixel clock. The image is displayed at the top-left of the screen; pixels outside the image are black.

---
 rtl/vga_scanout.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// Purpose: 640x480@60 VGA scanout of an IMG_W x IMG_H grayscale framebuffer, top-left aligned, black elsewhere.
// Latency: one pixel (2 clk); all video/sync outputs for pixel (h,v) register on the tick ending its window.
// Backpressure: none; free-running timing, framebuffer must return data one clk after the address.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC_W = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC_W = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              clk_25,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              H_SYNC,
  output logic              V_SYNC,
  output logic              SYNC_B,
  output logic              SYNC_BLANK,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC_W + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC_W + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int IWB     = $clog2(IMG_W);
  localparam int IHB     = $clog2(IMG_H);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC_W);
  localparam logic [HW-1:0] H_IMG  = HW'(IMG_W);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC_W);
  localparam logic [VW-1:0] V_IMG  = VW'(IMG_H);

  logic          phase_q, phase_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [7:0]    rgb_q, rgb_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_q, blank_d;
  logic          fs_q, fs_d;

  logic in_img;
  logic active;
  logic hs_on;
  logic vs_on;

  // Phase toggles every clk; counters step only on the tick (phase==1), v on h wrap.
  always_comb begin
    phase_d = ~phase_q;
    h_d     = h_q;
    v_d     = v_q;
    if (phase_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Region decode for the pixel currently addressed; drives the framebuffer port directly.
  always_comb begin
    in_img   = (h_q < H_IMG) && (v_q < V_IMG);
    active   = (h_q < H_ACT) && (v_q < V_ACT);
    hs_on    = (h_q >= H_SS) && (h_q < H_SE);
    vs_on    = (v_q >= V_SS) && (v_q < V_SE);
    mem_rd   = in_img;
    mem_addr = in_img ? {v_q[IHB-1:0], h_q[IWB-1:0]} : '0;
  end

  // Output registers capture the current pixel on the tick and hold otherwise; frame_start lasts one clk.
  always_comb begin
    rgb_d   = rgb_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    blank_d = blank_q;
    fs_d    = 1'b0;
    if (phase_q) begin
      rgb_d   = (in_img && active) ? mem_data : 8'h00;
      hs_d    = ~hs_on;
      vs_d    = ~vs_on;
      blank_d = active;
      fs_d    = (h_q == '0) && (v_q == '0);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      rgb_q   <= 8'h00;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      h_q     <= h_d;
      v_q     <= v_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
    end
  end

  assign clk_25      = phase_q;
  assign r           = rgb_q;
  assign g           = rgb_q;
  assign b           = rgb_q;
  assign H_SYNC      = hs_q;
  assign V_SYNC      = vs_q;
  assign SYNC_B      = 1'b0;
  assign SYNC_BLANK  = blank_q;
  assign frame_start = fs_q;

endmodule
